arb_requester: RTL and testbench

Requester-side agent for the two-bit bus arbiter. One instance sits in front of each requesting block, owns one bit of the arbiter's request vector, and watches the matching grant bit. It takes a burst command from its local block, raises and holds its request until granted, and issues one beat strobe per granted cycle. It releases the bus after the last beat, and it backs off and retries if a grant does not arrive within a bounded time.

---
 rtl/arb_requester.sv | 136 +++++++++++++
 tb/tb_arb_requester.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// Requester-side agent for the two-bit bus arbiter.
// Takes a burst command, requests the bus until granted, emits one beat per
// granted cycle, releases after the last beat, and backs off on grant timeout.
module arb_requester #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned BACKOFF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             beat_last,
  output logic             done,
  output logic             timeout_err
);

  // One counter serves both the grant wait and the backoff interval.
  localparam int unsigned WaitMax = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
  localparam int unsigned WaitW   = $clog2(WaitMax + 1);

  localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TIMEOUT - 1);
  localparam logic [WaitW-1:0] BackoffLast = WaitW'(BACKOFF - 1);
  localparam logic [WaitW-1:0] WaitOne     = WaitW'(1);
  localparam logic [LEN_W-1:0] BeatOne     = LEN_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StOwn,
    StRelease,
    StBackoff
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [WaitW-1:0]   wait_q, wait_d;

  // State and counter registers; reset abandons any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    cmd_ready   = 1'b0;
    req         = 1'b0;
    beat_valid  = 1'b0;
    beat_last   = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;

    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_d   = cmd_len;
          beat_d  = '0;
          wait_d  = '0;
          state_d = StReq;
        end
      end

      StReq: begin
        req    = 1'b1;
        wait_d = wait_q + WaitOne;
        // The registered grant may still reflect a previous tenure during the
        // first request cycle (wait_q == 0), so it is only honoured afterwards.
        // A grant in the timeout cycle takes priority over the timeout.
        if ((wait_q != '0) && gnt) begin
          wait_d  = '0;
          state_d = StOwn;
        end else if (wait_q == TimeoutLast) begin
          timeout_err = 1'b1;
          wait_d      = '0;
          state_d     = StBackoff;
        end
      end

      StOwn: begin
        req        = 1'b1;
        beat_valid = gnt;
        // Grant gaps simply stall the beat counter; no timeout while owning.
        if (gnt) begin
          if (beat_q == len_q) begin
            beat_last = 1'b1;
            beat_d    = '0;
            state_d   = StRelease;
          end else begin
            beat_d = beat_q + BeatOne;
          end
        end
      end

      StRelease: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      StBackoff: begin
        wait_d = wait_q + WaitOne;
        if (wait_q == BackoffLast) begin
          wait_d  = '0;
          state_d = StReq;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign beat_idx = beat_q;

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester with a beat scoreboard.
module tb_arb_requester;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned BACKOFF = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             req;
  logic             gnt;
  logic             beat_valid;
  logic [LEN_W-1:0] beat_idx;
  logic             beat_last;
  logic             done;
  logic             timeout_err;

  typedef struct {
    int unsigned idx;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       e;
  int unsigned vectors;
  int unsigned errors;
  int unsigned beats_seen;
  int unsigned beats_before;

  arb_requester #(
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT),
    .BACKOFF(BACKOFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .req        (req),
    .gnt        (gnt),
    .beat_valid (beat_valid),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .done       (done),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int unsigned len);
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back('{idx: i, last: (i == int'(len))});
    end
  endtask

  // Accept a command (caller is one cycle before the accepting edge).
  task automatic accept(input int unsigned len);
    cmd_len   = LEN_W'(len);
    cmd_valid = 1'b1;
    push_burst(len);
    #1;
    check("accept_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check("req_t1", req, 1'b1);
    check("ready_t1", cmd_ready, 1'b0);
  endtask

  // Full uninterrupted burst with gnt held high.
  task automatic run_burst(input int unsigned len);
    beats_before = beats_seen;
    gnt = 1'b1;
    accept(len);
    check("no_beat_t1", beat_valid, 1'b0);
    step();
    check("no_beat_t2", beat_valid, 1'b0);
    check("req_t2", req, 1'b1);
    step();
    for (int i = 0; i <= int'(len); i++) begin
      check("beat_valid", beat_valid, 1'b1);
      check("beat_idx", beat_idx, i);
      check("beat_last", beat_last, (i == int'(len)));
      check("req_own", req, 1'b1);
      step();
    end
    check("done", done, 1'b1);
    check("req_release", req, 1'b0);
    check("beat_after", beat_valid, 1'b0);
    step();
    check("done_pulse", done, 1'b0);
    check("ready_back", cmd_ready, 1'b1);
    check("beat_count", beats_seen - beats_before, len + 1);
    check("sb_drained", exp_q.size(), 0);
  endtask

  // Scoreboard: every beat must match the next expected beat.
  always @(negedge clk) begin
    if (reset && beat_valid) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sb_idx", beat_idx, e.idx);
        check("sb_last", beat_last, e.last);
      end
    end
  end

  initial begin
    vectors    = 0;
    errors     = 0;
    beats_seen = 0;

    // Reset with active inputs: nothing may happen.
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = '0;
    gnt       = 1'b1;
    repeat (3) step();
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_req", req, 1'b0);
    check("rst_beat", beat_valid, 1'b0);
    check("rst_idx", beat_idx, 0);
    check("rst_last", beat_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tmo", timeout_err, 1'b0);

    // Release reset; stale grant already high; 1-beat burst accepted next edge.
    reset = 1'b1;
    push_burst(0);
    step();
    cmd_valid = 1'b0;
    check("post_rst_req", req, 1'b1);
    check("post_rst_ready", cmd_ready, 1'b0);
    check("stale_t1", beat_valid, 1'b0);
    step();
    check("stale_t2", beat_valid, 1'b0);
    step();
    check("stale_t3_beat", beat_valid, 1'b1);
    check("stale_t3_last", beat_last, 1'b1);
    step();
    check("stale_done", done, 1'b1);
    step();
    check("stale_ready", cmd_ready, 1'b1);

    // Basic burst of 4 beats.
    run_burst(3);

    // Grant gap of 3 cycles after beat 2.
    beats_before = beats_seen;
    gnt = 1'b1;
    accept(5);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      check("gap_pre_idx", beat_idx, i);
      check("gap_pre_valid", beat_valid, 1'b1);
      step();
    end
    gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("gap_valid", beat_valid, 1'b0);
      check("gap_req", req, 1'b1);
      check("gap_idx_hold", beat_idx, 3);
      step();
    end
    gnt = 1'b1;
    #1;
    for (int i = 3; i <= 5; i++) begin
      check("gap_post_idx", beat_idx, i);
      check("gap_post_valid", beat_valid, 1'b1);
      check("gap_post_last", beat_last, (i == 5));
      step();
    end
    check("gap_done", done, 1'b1);
    step();
    check("gap_ready", cmd_ready, 1'b1);
    check("gap_beats", beats_seen - beats_before, 6);

    // Timeout and backoff with gnt held low.
    gnt = 1'b0;
    accept(1);
    for (int c = 1; c <= int'(TIMEOUT); c++) begin
      check("tmo_req", req, 1'b1);
      check("tmo_pulse", timeout_err, (c == int'(TIMEOUT)));
      step();
    end
    for (int c = 0; c < int'(BACKOFF); c++) begin
      check("bo_req", req, 1'b0);
      check("bo_tmo", timeout_err, 1'b0);
      check("bo_ready", cmd_ready, 1'b0);
      step();
    end
    check("retry_req", req, 1'b1);
    gnt = 1'b1;
    #1;
    check("retry_first_ignored", beat_valid, 1'b0);
    step();
    check("retry_t2", beat_valid, 1'b0);
    step();
    check("retry_beat0", beat_idx, 0);
    check("retry_valid0", beat_valid, 1'b1);
    step();
    check("retry_beat1_last", beat_last, 1'b1);
    step();
    check("retry_done", done, 1'b1);
    step();
    check("retry_ready", cmd_ready, 1'b1);

    // Grant arriving in the timeout cycle wins.
    gnt = 1'b0;
    accept(0);
    repeat (TIMEOUT - 1) step();
    check("win_tmo_pending", timeout_err, 1'b1);
    gnt = 1'b1;
    #1;
    check("win_no_tmo", timeout_err, 1'b0);
    step();
    check("win_beat", beat_valid, 1'b1);
    check("win_last", beat_last, 1'b1);
    step();
    check("win_done", done, 1'b1);
    step();

    // Maximum length burst.
    run_burst(15);

    // Reset abort after beat 7 of a max burst.
    gnt = 1'b1;
    accept(15);
    step();
    step();
    repeat (7) step();
    check("abort_idx7", beat_idx, 7);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_req", req, 1'b0);
    check("abort_beat", beat_valid, 1'b0);
    check("abort_ready", cmd_ready, 1'b1);
    exp_q.delete();
    step();
    step();
    reset = 1'b1;
    #1;
    check("abort_post_ready", cmd_ready, 1'b1);
    check("abort_post_req", req, 1'b0);
    check("abort_post_done", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
